// File: rtl/status_report_encoder_pkg.sv
// status_report_encoder_pkg: frame constants, ctrl codes and FSM states shared by the status reply path
package status_report_encoder_pkg;
  localparam logic [7:0] HEADER_DEF = 8'hA5;
  localparam logic [7:0] TAIL_DEF = 8'h5A;
  localparam logic [3:0] CTRL_MOVE = 4'h0;
  localparam logic [3:0] CTRL_SCREEN = 4'h1;
  localparam int FRAME_LEN = 5;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/status_report_encoder_if.sv
// status_report_encoder_if: valid/ready byte handshake toward the UART transmitter
interface status_report_encoder_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/status_report_encoder_value_encode.sv
// status_value_encode: maps split/full flag and one-hot screen selection to the 4-bit reply value (4'hF if invalid)
module status_value_encode (
  input logic split_full,
  input logic [3:0] screen_switch,
  output logic [3:0] value
);
  always_comb
    value = !split_full ? 4'd0 :
            screen_switch == 4'b0001 ? 4'd1 :
            screen_switch == 4'b0010 ? 4'd2 :
            screen_switch == 4'b0100 ? 4'd3 :
            screen_switch == 4'b1000 ? 4'd4 : 4'hF;
endmodule

// File: rtl/status_report_encoder.sv
// status_report_encoder: streams a 5-byte status frame from a snapshot of control state; AUTO_REPORT_EN adds change-triggered reports
module status_report_encoder
  import status_report_encoder_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEF,
  parameter logic [7:0] TAIL = TAIL_DEF
) (
  input logic clk,
  input logic rst,
  input logic I_report_req,
  input logic I_video_move_en,
  input logic I_split_full_flag,
  input logic [3:0] I_screen_switch,
  status_report_encoder_if.master tx,
  output logic O_busy,
  output logic O_frame_done
);
  state_t state, state_nx;
  logic [2:0] idx, idx_nx;
  logic snap_move, snap_split, pending, pending_nx, trigger, xfer, last, auto_hit;
  logic [3:0] snap_switch, snap_value;
  logic [7:0] b1, b2;
  status_value_encode u_value (
    .split_full(snap_split),
    .screen_switch(snap_switch),
    .value(snap_value)
  );
`ifdef AUTO_REPORT_EN
  logic [5:0] reported;
  always_ff @(posedge clk) begin
    if (rst) reported <= '0;
    else if (trigger) reported <= {I_video_move_en, I_split_full_flag, I_screen_switch};
  end
  assign auto_hit = {I_video_move_en, I_split_full_flag, I_screen_switch} != reported;
`else
  assign auto_hit = 1'b0;
`endif
  always_comb begin
    xfer = state == SEND && tx.tx_ready;
    last = idx == 3'(FRAME_LEN - 1);
    trigger = state == IDLE && (I_report_req || pending || auto_hit);
    state_nx = trigger ? SEND : xfer && last ? IDLE : state;
    idx_nx = trigger ? 3'd0 : xfer && !last ? idx + 3'd1 : idx;
    pending_nx = state == SEND && (pending || I_report_req);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= 3'd0;
      pending <= 1'b0;
      O_frame_done <= 1'b0;
      snap_move <= 1'b0;
      snap_split <= 1'b0;
      snap_switch <= 4'd0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      pending <= pending_nx;
      O_frame_done <= xfer && last;
      if (trigger) begin
        snap_move <= I_video_move_en;
        snap_split <= I_split_full_flag;
        snap_switch <= I_screen_switch;
      end
    end
  end
  assign b1 = {CTRL_MOVE, 3'b000, snap_move};
  assign b2 = {CTRL_SCREEN, snap_value};
  assign tx.tx_valid = state == SEND;
  assign O_busy = state == SEND;
  assign tx.tx_data = state != SEND ? 8'h00 :
                      idx == 3'd0 ? HEADER :
                      idx == 3'd1 ? b1 :
                      idx == 3'd2 ? b2 :
                      idx == 3'd3 ? b1 ^ b2 : TAIL;
endmodule

// File: tb/tb_status_report_encoder.sv
// tb_status_report_encoder: queue-based frame model checked every cycle plus hand-computed frame literals
module tb_status_report_encoder;
  logic clk = 0, rst = 1, req = 0, mv = 0, sf = 0, rdy = 1;
  logic [3:0] sw = 4'd0;
  logic busy, done;
  int checks = 0, errors = 0;
  status_report_encoder_if tx ();
  assign tx.tx_ready = rdy;
  status_report_encoder dut (
    .clk(clk),
    .rst(rst),
    .I_report_req(req),
    .I_video_move_en(mv),
    .I_split_full_flag(sf),
    .I_screen_switch(sw),
    .tx(tx),
    .O_busy(busy),
    .O_frame_done(done)
  );
  always #5 clk = ~clk;
  logic [7:0] mq[$];
  logic [7:0] got[$];
  logic pend_m = 0, done_m = 0, chk_en = 0, idle_trig;
  logic [5:0] last_m = 6'd0;
  logic [7:0] m1, m2;
  logic [39:0] t1 = 40'hA5_01_10_11_5A;
  function automatic logic [7:0] screen_byte(logic s, logic [3:0] w);
    if (!s) return 8'h10;
    case (w)
      4'b0001: return 8'h11;
      4'b0010: return 8'h12;
      4'b0100: return 8'h13;
      4'b1000: return 8'h14;
      default: return 8'h1F;
    endcase
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      pend_m = 0;
      done_m = 0;
      last_m = 6'd0;
    end else begin
      done_m = 0;
      if (mq.size() != 0) begin
        if (rdy) begin
          void'(mq.pop_front());
          done_m = mq.size() == 0;
        end
        if (req) pend_m = 1;
      end else begin
`ifdef AUTO_REPORT_EN
        idle_trig = req || pend_m || {mv, sf, sw} != last_m;
`else
        idle_trig = req || pend_m;
`endif
        if (idle_trig) begin
          m1 = {7'd0, mv};
          m2 = screen_byte(sf, sw);
          mq = '{8'hA5, m1, m2, m1 ^ m2, 8'h5A};
          pend_m = 0;
          last_m = {mv, sf, sw};
        end
      end
    end
  end
  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 8'(tx.tx_valid), 8'(mq.size() != 0));
      chk("data", tx.tx_data, mq.size() != 0 ? mq[0] : 8'h00);
      chk("busy", 8'(busy), 8'(mq.size() != 0));
      chk("done", 8'(done), 8'(done_m));
      if (tx.tx_valid && rdy && !rst) got.push_back(tx.tx_data);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_req();
    req = 1;
    step();
    req = 0;
  endtask
  task automatic wait_quiet(string name);
    int n = 0, q = 0;
    while (q < 3 && n < 200) begin
      step();
      n++;
      q = (busy || mq.size() != 0 || pend_m) ? 0 : q + 1;
    end
    checks++;
    if (q < 3) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles", name, n);
    end
  endtask
  task automatic check_frame(string name, logic [39:0] f);
    logic [7:0] a;
    for (int i = 0; i < 5; i++) begin
      a = 8'hxx;
      if (got.size() != 0) a = got.pop_front();
      chk(name, a, f[39-8*i -: 8]);
    end
  endtask
  task automatic check_none(string name);
    chk(name, 8'(got.size()), 8'd0);
    got.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    @(posedge clk);
    #1;
    chk_en = 1;
    step();
    @(negedge clk);
    chk("rst_valid", 8'(tx.tx_valid), 8'd0);
    chk("rst_data", tx.tx_data, 8'h00);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    step();
    rst = 0;
    mv = 1; sf = 0; sw = 4'd0;
    pulse_req();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t1_byte", tx.tx_data, t1[39-8*i -: 8]);
      chk("t1_valid", 8'(tx.tx_valid), 8'd1);
    end
    @(negedge clk);
    chk("t1_done", 8'(done), 8'd1);
    chk("t1_idle", 8'(tx.tx_valid), 8'd0);
    wait_quiet("t1_quiet");
    check_frame("t1_frame", 40'hA5_01_10_11_5A);
    check_none("t1_extra");
    mv = 0; sf = 1; sw = 4'b0100;
    pulse_req();
    wait_quiet("t2_quiet");
    check_frame("t2_frame", 40'hA5_00_13_13_5A);
    check_none("t2_extra");
    pulse_req();
    step();
    step();
    rdy = 0;
    repeat (2) begin
      @(negedge clk);
      chk("t3_hold_data", tx.tx_data, 8'h13);
      chk("t3_hold_valid", 8'(tx.tx_valid), 8'd1);
      step();
    end
    rdy = 1;
    wait_quiet("t3_quiet");
    check_frame("t3_frame", 40'hA5_00_13_13_5A);
    check_none("t3_extra");
    sw = 4'b0001;
    pulse_req();
    req = 1; sw = 4'b1000;
    step();
    req = 0;
    step();
    req = 1;
    step();
    req = 0;
    step();
    req = 1;
    step();
    req = 0;
    wait_quiet("t4_quiet");
    check_frame("t4_frame0", 40'hA5_00_11_11_5A);
    check_frame("t4_frame1", 40'hA5_00_14_14_5A);
    check_none("t4_extra");
    sw = 4'b0110;
    pulse_req();
    wait_quiet("t5_quiet");
    check_frame("t5_frame", 40'hA5_00_1F_1F_5A);
    check_none("t5_extra");
    mv = 1;
    pulse_req();
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("t5_abort_valid", 8'(tx.tx_valid), 8'd0);
    chk("t5_abort_busy", 8'(busy), 8'd0);
    chk("t5_partial", 8'(got.size()), 8'd2);
    got.delete();
    step();
`ifndef AUTO_REPORT_EN
    pulse_req();
`endif
    wait_quiet("t5_restart_quiet");
    check_frame("t5_restart", 40'hA5_01_1F_1E_5A);
    check_none("t5_restart_extra");
`ifdef AUTO_REPORT_EN
    rst = 1; mv = 0; sf = 0; sw = 4'd0;
    step();
    step();
    rst = 0;
    wait_quiet("t6_quiet0");
    check_none("t6_none");
    mv = 1;
    wait_quiet("t6_quiet1");
    check_frame("t6_frame", 40'hA5_01_10_11_5A);
    repeat (20) step();
    check_none("t6_stable");
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
